// File: rtl/pipe_adder_seg.sv
// pipe_adder_seg: segmented, pipelined W-bit adder with valid/ready on both sides.
// Each stage adds one SEG-bit slice and forwards its carry to the next stage.
// The stage holds only what it still needs: finished low sum bits, a carry,
// and the operand bits above its slice. W must be a multiple of SEG.
// Optional feature: define PIPE_ADD_SUB_EN to add the 'sub' port (a - b).
module pipe_adder_seg #(
  parameter int W   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef PIPE_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int STAGES = W / SEG;

  // Effective B operand and carry-in. Subtract is folded in here, so it is
  // captured together with the operands on accept.
  logic [W-1:0] w_b_eff;
  logic         w_c_eff;
`ifdef PIPE_ADD_SUB_EN
  assign w_b_eff = sub ? ~b : b;
  assign w_c_eff = sub | cin;
`else
  assign w_b_eff = b;
  assign w_c_eff = cin;
`endif

  // Stage valid bits gathered so each stage can see whether anything
  // downstream of it has a free slot.
  logic [STAGES-1:0] w_vld;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    localparam int LO = i * SEG;   // sum bits already finished on entry
    localparam int HI = W - LO;    // operand bits still to be added on entry

    logic [HI-1:0]     w_ain;
    logic [HI-1:0]     w_bin;
    logic              w_cin;
    logic              w_vin;
    logic              w_adv;
    logic [SEG:0]      w_seg;
    logic [LO+SEG-1:0] w_s_nxt;
    logic              r_v;
    logic              r_c;
    logic [LO+SEG-1:0] r_s;

    if (i == 0) begin : g_in
      assign w_vin   = in_valid;
      assign w_ain   = a;
      assign w_bin   = w_b_eff;
      assign w_cin   = w_c_eff;
      assign w_s_nxt = w_seg[SEG-1:0];
    end else begin : g_in
      assign w_vin   = g_stg[i-1].r_v;
      assign w_ain   = g_stg[i-1].g_op.r_a;
      assign w_bin   = g_stg[i-1].g_op.r_b;
      assign w_cin   = g_stg[i-1].r_c;
      assign w_s_nxt = {w_seg[SEG-1:0], g_stg[i-1].r_s};
    end

    assign w_seg    = {1'b0, w_ain[SEG-1:0]} + {1'b0, w_bin[SEG-1:0]} + {{SEG{1'b0}}, w_cin};
    // A stage may move when it, or any stage after it, is empty, or the
    // consumer takes the result. Written without a ripple chain.
    assign w_adv    = out_ready | ~(&w_vld[STAGES-1:i]);
    assign w_vld[i] = r_v;

    // Valid, carry and partial sum; data only changes when a valid beat enters
    // so a stalled or drained stage keeps its last contents.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vin;
        if (w_vin) begin
          r_c <= w_seg[SEG];
          r_s <= w_s_nxt;
        end
      end
    end

    if (i < STAGES-1) begin : g_op
      logic [HI-SEG-1:0] r_a;
      logic [HI-SEG-1:0] r_b;

      // Operand bits above this slice travel on to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vin) begin
          r_a <= w_ain[HI-1:SEG];
          r_b <= w_bin[HI-1:SEG];
        end
      end
    end else begin : g_last
      logic r_ov;

      // Signed overflow from the top slice: the operand sign bits are the
      // slice MSBs here, the result sign is the new sum MSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_ov <= 1'b0;
        end else if (w_adv && w_vin) begin
          r_ov <= (w_ain[SEG-1] == w_bin[SEG-1]) & (w_seg[SEG-1] != w_ain[SEG-1]);
        end
      end
    end
  end

  assign in_ready  = g_stg[0].w_adv;
  assign out_valid = g_stg[STAGES-1].r_v;
  assign sum       = g_stg[STAGES-1].r_s;
  assign cout      = g_stg[STAGES-1].r_c;
  assign ovf       = g_stg[STAGES-1].g_last.r_ov;

endmodule

// File: tb/tb_pipe_adder_seg.sv
// Directed bench for pipe_adder_seg (W=32, SEG=8, four stages).
module tb_pipe_adder_seg;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef PIPE_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  pipe_adder_seg #(.W(W), .SEG(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
`ifdef PIPE_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference result packed as {cout, ovf, sum}.
  function automatic logic [33:0] mres(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    logic       o;
    f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
    return {f[W], o, f[W-1:0]};
  endfunction

  function automatic logic [W-1:0] op_a(input int j);
    return 32'h89ABCDEF + 32'(j) * 32'h10101011;
  endfunction
  function automatic logic [W-1:0] op_b(input int j);
    return 32'h7654321F ^ (32'(j) << 5);
  endfunction
  function automatic logic op_c(input int j);
    return j[0];
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    in_valid = v;
    a = x;
    b = y;
    cin = c;
  endtask

  // One isolated op: reports in_ready at accept, accept-to-valid latency and the result.
  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         output logic rdy, output int lat, output logic [33:0] res, output logic got);
    drive(1'b1, x, y, c);
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    lat = 1;
    got = 1'b0;
    res = '0;
    while (!got && lat <= 20) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        res = {cout, ovf, sum};
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++;
    if ({cout, ovf, sum} !== 34'h0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", {cout, ovf, sum}); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic         vc [6];
    logic [33:0]  ve [6];
    logic         rdy, got;
    int           lat;
    logic [33:0]  res;
    va = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h80000000, 32'h000000FF, 32'h00FFFFFF};
    vb = '{32'h00000001, 32'h00000001, 32'h11111111, 32'h80000000, 32'h00000001, 32'h00000000};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ve = '{{1'b1, 1'b0, 32'h00000000}, {1'b0, 1'b1, 32'h80000000}, {1'b0, 1'b0, 32'h2345678A},
           {1'b1, 1'b1, 32'h00000000}, {1'b0, 1'b0, 32'h00000100}, {1'b0, 1'b0, 32'h01000000}};
    for (int i = 0; i < 6; i++) begin
      run_one(va[i], vb[i], vc[i], rdy, lat, res, got);
      tests++;
      if (got !== 1'b1) begin fails++; $display("FAIL add_timeout vec=%0d got no result exp out_valid", i); end
      tests++;
      if (rdy !== 1'b1) begin fails++; $display("FAIL add_in_ready vec=%0d got=%b exp=1", i, rdy); end
      tests++;
      if (lat != 4) begin fails++; $display("FAIL add_latency vec=%0d got=%0d exp=4", i, lat); end
      tests++;
      if (res !== ve[i]) begin fails++; $display("FAIL add_result vec=%0d got=%h exp=%h", i, res, ve[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e;
    out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t < 10) drive(1'b1, op_a(t), op_b(t), op_c(t));
      else        drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      if (t < 10) begin
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready cycle=%0d got=%b exp=1", t, in_ready); end
      end
      tests++;
      if (out_valid !== (t >= 4 && t <= 13)) begin
        fails++; $display("FAIL b2b_out_valid cycle=%0d got=%b exp=%b", t, out_valid, (t >= 4 && t <= 13));
      end
      if (t >= 4 && t <= 13) begin
        e = mres(op_a(t-4), op_b(t-4), op_c(t-4));
        tests++;
        if ({cout, ovf, sum} !== e) begin fails++; $display("FAIL b2b_result cycle=%0d got=%h exp=%h", t, {cout, ovf, sum}, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int          n;
    logic [33:0] e;
    out_ready = 1'b0;
    n = 0;
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, op_a(20+n), op_b(20+n), op_c(20+n));
      @(negedge clk);
      tests++;
      if (in_ready !== (n < 4)) begin fails++; $display("FAIL stall_in_ready cycle=%0d got=%b exp=%b", t, in_ready, (n < 4)); end
      if (in_ready) n++;
      @(posedge clk); #1;
    end
    tests++;
    if (n != 4) begin fails++; $display("FAIL stall_accept_count got=%0d exp=4", n); end
    e = mres(op_a(20), op_b(20), op_c(20));
    tests++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, e}) begin
      fails++; $display("FAIL stall_hold got=%h exp=%h", {out_valid, cout, ovf, sum}, {1'b1, e});
    end
    // Release: accept of op 24 and emit of op 20 on the same edge.
    out_ready = 1'b1;
    drive(1'b1, op_a(24), op_b(24), op_c(24));
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_in_ready got=%b exp=1", in_ready); end
    tests++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, e}) begin
      fails++; $display("FAIL stall_release_first got=%h exp=%h", {out_valid, cout, ovf, sum}, {1'b1, e});
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = mres(op_a(20+k), op_b(20+k), op_c(20+k));
      tests++;
      if ({out_valid, cout, ovf, sum} !== {1'b1, e}) begin
        fails++; $display("FAIL stall_drain k=%0d got=%h exp=%h", k, {out_valid, cout, ovf, sum}, {1'b1, e});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(1'b1, 32'h80000000, 32'h80000001, 1'b0);
    @(posedge clk); #1;
    for (int t = 1; t < 4; t++) begin
      drive(1'b1, op_a(40+t), op_b(40+t), op_c(40+t));
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0);
    tests++;
    if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b1, 32'h00000001}) begin
      fails++; $display("FAIL rstmid_before got=%h exp=%h", {out_valid, cout, ovf, sum}, {1'b1, 1'b1, 1'b1, 32'h00000001});
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    tests++;
    if ({cout, ovf, sum} !== 34'h0) begin fails++; $display("FAIL rstmid_outputs got=%h exp=0", {cout, ovf, sum}); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale cycle=%0d got=%b exp=0", t, out_valid); end
      @(posedge clk); #1;
    end
  endtask

`ifdef PIPE_ADD_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [33:0]  ve [4];
    logic         rdy, got;
    int           lat;
    logic [33:0]  res;
    va = '{32'h00000005, 32'h00000007, 32'h00000007, 32'h80000000};
    vb = '{32'h00000007, 32'h00000005, 32'h00000005, 32'h00000001};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    ve = '{{1'b0, 1'b0, 32'hFFFFFFFE}, {1'b1, 1'b0, 32'h00000002},
           {1'b1, 1'b0, 32'h00000002}, {1'b1, 1'b1, 32'h7FFFFFFF}};
    sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], vb[i], vc[i], rdy, lat, res, got);
      tests++;
      if (got !== 1'b1) begin fails++; $display("FAIL sub_timeout vec=%0d got no result exp out_valid", i); end
      tests++;
      if (res !== ve[i]) begin fails++; $display("FAIL sub_result vec=%0d got=%h exp=%h", i, res, ve[i]); end
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef PIPE_ADD_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
